// File: rtl/t9990_slot_arbiter.sv
// t9990_slot_arbiter: shares the single VRAM port between refresh, SP, PA, PB,
// BP and the VDP/CPU channel (VC). One grant per SLOT, held until DONE, then a
// one-cycle ACK. Refresh scheduling is compiled in only when the macro
// T9990_SLOT_RFSH_EN is defined; otherwise GNT_RFSH/ACK_RFSH are tied low.
module t9990_slot_arbiter #(
  parameter int unsigned RFSH_INTERVAL = 64,
  parameter int unsigned VC_MAX_WAIT   = 8
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       SLOT,
  input  logic       DONE,
  input  logic [4:0] REQ,
  output logic [4:0] GNT,
  output logic       GNT_RFSH,
  output logic [4:0] ACK,
  output logic       ACK_RFSH,
  output logic       BUSY
);

  localparam int unsigned NREQ   = 5;
  localparam int unsigned VCW    = 4;
  localparam int unsigned RCW    = 8;
  localparam logic [VCW-1:0] VC_MAX = VCW'(VC_MAX_WAIT);
  localparam logic [VCW-1:0] VC_SAT = {VCW{1'b1}};

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  // Reject out-of-range parameterisations at elaboration
  if (RFSH_INTERVAL < 2 || RFSH_INTERVAL > 256) begin : g_bad_rfsh
    $error("RFSH_INTERVAL out of range 2..256");
  end
  if (VC_MAX_WAIT < 1 || VC_MAX_WAIT > 15) begin : g_bad_vc
    $error("VC_MAX_WAIT out of range 1..15");
  end

  logic            state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [VCW-1:0]  vc_wait_q, vc_wait_d;
  logic [NREQ-1:0] pick;
  logic            pick_rfsh;
  logic            vc_promo;

`ifdef T9990_SLOT_RFSH_EN
  localparam logic [RCW-1:0] RFSH_LAST = RCW'(RFSH_INTERVAL - 1);
  logic            gnt_rfsh_q, gnt_rfsh_d;
  logic            ack_rfsh_q, ack_rfsh_d;
  logic            rfsh_pend_q, rfsh_pend_d;
  logic [RCW-1:0]  rfsh_cnt_q, rfsh_cnt_d;
`endif

  assign vc_promo = (vc_wait_q == VC_MAX);

  // Fixed-priority pick of at most one candidate from the sampled requests
  always_comb begin
    pick      = '0;
    pick_rfsh = 1'b0;
`ifdef T9990_SLOT_RFSH_EN
    if (rfsh_pend_q)              pick_rfsh = 1'b1;
    else
`endif
    if (REQ[0])                   pick[0] = 1'b1;
    else if (REQ[4] && vc_promo)  pick[4] = 1'b1;
    else if (REQ[1])              pick[1] = 1'b1;
    else if (REQ[2])              pick[2] = 1'b1;
    else if (REQ[3])              pick[3] = 1'b1;
    else if (REQ[4])              pick[4] = 1'b1;
  end

  // Next-state, grant/ack and counter update
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    vc_wait_d = vc_wait_q;
`ifdef T9990_SLOT_RFSH_EN
    gnt_rfsh_d  = gnt_rfsh_q;
    ack_rfsh_d  = 1'b0;
    rfsh_pend_d = rfsh_pend_q;
    rfsh_cnt_d  = rfsh_cnt_q;
    if (SLOT) begin
      if (rfsh_cnt_q == RFSH_LAST) rfsh_cnt_d = '0;
      else                         rfsh_cnt_d = rfsh_cnt_q + RCW'(1);
    end
`endif

    case (state_q)
      ST_IDLE: begin
        if (SLOT) begin
          if (pick != '0 || pick_rfsh) begin
            gnt_d   = pick;
            state_d = ST_GRANT;
          end
`ifdef T9990_SLOT_RFSH_EN
          if (pick_rfsh) begin
            gnt_rfsh_d  = 1'b1;
            rfsh_pend_d = 1'b0;
          end
`endif
          // Refusal counting only happens on slots seen while idle
          if (REQ[4]) begin
            if (pick[4])                 vc_wait_d = '0;
            else if (vc_wait_q != VC_SAT) vc_wait_d = vc_wait_q + VCW'(1);
          end
        end
      end
      default: begin
        if (DONE) begin
          gnt_d   = '0;
          ack_d   = gnt_q;
          state_d = ST_IDLE;
`ifdef T9990_SLOT_RFSH_EN
          gnt_rfsh_d = 1'b0;
          ack_rfsh_d = gnt_rfsh_q;
`endif
        end
      end
    endcase

    if (!REQ[4]) vc_wait_d = '0;

`ifdef T9990_SLOT_RFSH_EN
    // A wrap re-arms refresh even on the slot that consumes the old request
    if (SLOT && (rfsh_cnt_q == RFSH_LAST)) rfsh_pend_d = 1'b1;
`endif
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      ack_q     <= '0;
      vc_wait_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      vc_wait_q <= vc_wait_d;
    end
  end

`ifdef T9990_SLOT_RFSH_EN
  // Refresh scheduling registers
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      gnt_rfsh_q  <= 1'b0;
      ack_rfsh_q  <= 1'b0;
      rfsh_pend_q <= 1'b0;
      rfsh_cnt_q  <= '0;
    end else begin
      gnt_rfsh_q  <= gnt_rfsh_d;
      ack_rfsh_q  <= ack_rfsh_d;
      rfsh_pend_q <= rfsh_pend_d;
      rfsh_cnt_q  <= rfsh_cnt_d;
    end
  end

  assign GNT_RFSH = gnt_rfsh_q;
  assign ACK_RFSH = ack_rfsh_q;
`else
  assign GNT_RFSH = 1'b0;
  assign ACK_RFSH = 1'b0;
`endif

  assign GNT  = gnt_q;
  assign ACK  = ack_q;
  assign BUSY = (state_q == ST_GRANT);

endmodule

// File: tb/tb_t9990_slot_arbiter.sv
// Testbench for t9990_slot_arbiter: table-driven vectors plus hand-written
// sequences for VC promotion, refresh scheduling and asynchronous reset.
module tb_t9990_slot_arbiter;

  logic       clk;
  logic       reset_n;
  logic       slot;
  logic       done;
  logic [4:0] req;
  logic [4:0] gnt, ack, r_gnt, r_ack;
  logic       gnt_rfsh, ack_rfsh, busy, r_gnt_rfsh, r_ack_rfsh, r_busy;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef T9990_SLOT_RFSH_EN
  localparam bit RFSH_ON = 1'b1;
`else
  localparam bit RFSH_ON = 1'b0;
`endif

  t9990_slot_arbiter #(.RFSH_INTERVAL(256), .VC_MAX_WAIT(8)) u_dut (
    .CLK(clk), .RESET_n(reset_n), .SLOT(slot), .DONE(done), .REQ(req),
    .GNT(gnt), .GNT_RFSH(gnt_rfsh), .ACK(ack), .ACK_RFSH(ack_rfsh), .BUSY(busy)
  );

  t9990_slot_arbiter #(.RFSH_INTERVAL(4), .VC_MAX_WAIT(8)) u_dut_r (
    .CLK(clk), .RESET_n(reset_n), .SLOT(slot), .DONE(done), .REQ(req),
    .GNT(r_gnt), .GNT_RFSH(r_gnt_rfsh), .ACK(r_ack), .ACK_RFSH(r_ack_rfsh), .BUSY(r_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       slot;
    logic       done;
    logic [4:0] req;
    logic [4:0] gnt;
    logic [4:0] ack;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic d, input logic [4:0] r,
                     input logic [4:0] g, input logic [4:0] a, input logic b);
    vec_t v;
    v.slot = s; v.done = d; v.req = r; v.gnt = g; v.ack = a; v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_main(input string nm, input logic [4:0] eg, input logic [4:0] ea,
                          input logic eb);
    chk({nm, ".gnt"}, gnt, eg);
    chk({nm, ".ack"}, ack, ea);
    chk({nm, ".busy"}, 5'(busy), 5'(eb));
    chk({nm, ".gnt_rfsh"}, 5'(gnt_rfsh), 5'd0);
    chk({nm, ".ack_rfsh"}, 5'(ack_rfsh), 5'd0);
  endtask

  // Apply inputs for one clock edge, then look just after the edge
  task automatic step(input logic s, input logic d, input logic [4:0] r);
    slot = s; done = d; req = r;
    @(posedge clk); #1;
    slot = 1'b0; done = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; slot = 1'b0; done = 1'b0; req = '0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; slot = 1'b0; done = 1'b0; req = '0;

    // Reset state and idle behaviour
    add(0, 0, 5'b00000, 5'b00000, 5'b00000, 0);
    // SP access, DONE three cycles after the grant
    add(1, 0, 5'b00001, 5'b00001, 5'b00000, 1);
    add(0, 0, 5'b00001, 5'b00001, 5'b00000, 1);
    add(0, 0, 5'b00001, 5'b00001, 5'b00000, 1);
    add(0, 1, 5'b00001, 5'b00000, 5'b00001, 0);
    add(0, 0, 5'b00001, 5'b00000, 5'b00000, 0);
    // Request dropping mid-access still completes with ACK
    add(1, 0, 5'b00010, 5'b00010, 5'b00000, 1);
    add(0, 0, 5'b00000, 5'b00010, 5'b00000, 1);
    add(0, 1, 5'b00000, 5'b00000, 5'b00010, 0);
    // PA beats PB/BP three times in a row
    for (int i = 0; i < 3; i++) begin
      add(1, 0, 5'b01110, 5'b00010, 5'b00000, 1);
      add(0, 1, 5'b01110, 5'b00000, 5'b00010, 0);
    end
    // Drop PA -> PB, then drop PB -> BP
    add(1, 0, 5'b01100, 5'b00100, 5'b00000, 1);
    add(0, 1, 5'b01100, 5'b00000, 5'b00100, 0);
    add(1, 0, 5'b01000, 5'b01000, 5'b00000, 1);
    add(0, 1, 5'b00000, 5'b00000, 5'b01000, 0);
    // SLOT with nothing requested, DONE while idle
    add(1, 0, 5'b00000, 5'b00000, 5'b00000, 0);
    add(0, 1, 5'b00000, 5'b00000, 5'b00000, 0);
    // SLOT and DONE together while busy: completes, slot is lost
    add(1, 0, 5'b00001, 5'b00001, 5'b00000, 1);
    add(1, 1, 5'b00001, 5'b00000, 5'b00001, 0);
    add(0, 0, 5'b00001, 5'b00000, 5'b00000, 0);
    add(1, 0, 5'b00001, 5'b00001, 5'b00000, 1);
    add(0, 1, 5'b00000, 5'b00000, 5'b00001, 0);

    do_reset();
    foreach (vecs[i]) begin
      step(vecs[i].slot, vecs[i].done, vecs[i].req);
      chk_main($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].ack, vecs[i].busy);
    end

    // VC starvation protection; slots during a busy access are not refusals
    do_reset();
    for (int i = 0; i < 9; i++) begin
      logic [4:0] e;
      e = (i == 8) ? 5'b10000 : 5'b01000;
      step(1, 0, 5'b11000);
      chk($sformatf("vc%0d.gnt", i), gnt, e);
      if (i < 8) begin
        step(1, 0, 5'b11000);
        chk($sformatf("vc%0d.hold", i), gnt, e);
      end
      step(0, 1, 5'b11000);
      chk($sformatf("vc%0d.ack", i), ack, e);
    end
    step(1, 0, 5'b11000);
    chk("vc_after.gnt", gnt, 5'b01000);
    step(0, 1, 5'b11000);
    chk("vc_after.ack", ack, 5'b01000);

    // Refresh every 4th slot overrides SP (interval-4 instance)
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      logic rf;
      rf = RFSH_ON && (k > 1) && ((k % 4) == 1);
      step(1, 0, 5'b00001);
      chk($sformatf("rf%0d.gnt", k), r_gnt, rf ? 5'b00000 : 5'b00001);
      chk($sformatf("rf%0d.gnt_rfsh", k), 5'(r_gnt_rfsh), 5'(rf));
      step(0, 1, 5'b00001);
      chk($sformatf("rf%0d.ack", k), r_ack, rf ? 5'b00000 : 5'b00001);
      chk($sformatf("rf%0d.ack_rfsh", k), 5'(r_ack_rfsh), 5'(rf));
    end

    // Asynchronous reset in the middle of a VC access
    do_reset();
    step(1, 0, 5'b10000);
    chk("rst.pre_gnt", gnt, 5'b10000);
    #2 reset_n = 1'b0;
    #1;
    chk_main("rst.async", 5'b00000, 5'b00000, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    step(0, 1, 5'b10000);
    chk_main("rst.done_ignored", 5'b00000, 5'b00000, 0);
    step(0, 0, 5'b00000);
    chk_main("rst.quiet", 5'b00000, 5'b00000, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
